faller: RTL
===========

Name: faller

Overview:
- Upstream producer for the stack collision stage. Spawns one falling block at a pseudo-random x with a pseudo-random non-zero colour, then moves it down the screen at a tick-paced speed.
- Drives fall_x / fall_y / fall_color into the stack stage and consumes its collision flag to retire the block.
- Tracks misses, lives and catch score, and owns the game start/over sequencing.

Parameters:
- TICK_DIV, 250000, clk cycles per motion tick (min 2).
- SPAWN_Y, 0, fall_y loaded at spawn.
- FLOOR_Y, 470, fall_y at or beyond which the block is a miss (must be <= 1000).
- X_MIN, 40, leftmost spawn x; X_MIN+511 must be <= 639.
- RESPAWN_TICKS, 30, ticks spent hidden between retire and next spawn (>= 1).
- LIVES, 3, lives loaded at start (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  start/restart pulse; honoured only in IDLE or OVER.
- collision  in  1  registered catch flag from the stack stage.
- fall_x  out  10  block x (top-left); 0 when hidden.
- fall_y  out  10  block y (top-left); 10'h3FF when hidden.
- fall_color  out  2  block colour, never 2'b00 while active.
- active  out  1  block visible and falling.
- miss  out  1  one-cycle pulse when block reaches FLOOR_Y.
- lives  out  2  remaining lives.
- score  out  8  blocks caught, saturating at 255.
- game_over  out  1  high in OVER.

Behaviour:
- Reset is asynchronous (rst, active-high) on clk. Reset values: fall_x=0, fall_y=10'h3FF, fall_color=0, active=0, miss=0, lives=LIVES, score=0, game_over=0, state=IDLE, divider=0, LFSR=16'hACE1.
- Hidden position (x=0, y=3FF) lies outside any stack collision window by construction.
- Tick divider:
  - Free-running from reset: counts 0..TICK_DIV-1, wraps to 0.
  - tick=1 for the single cycle where the count equals TICK_DIV-1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk cycle in every state; never all-zero.
- State IDLE:
  - Outputs hidden.
  - start -> load lives=LIVES, score=0 -> SPAWN.
- State SPAWN (exactly 1 cycle):
  - fall_x = X_MIN + lfsr[8:0].
  - fall_color = lfsr[11:10], with 2'b00 replaced by 2'b01.
  - fall_y = SPAWN_Y, active=1 -> FALL.
- State FALL:
  - Each tick: fall_y <= fall_y + step, where step = 1 + min(score>>2, 3), giving range 1..4.
  - collision=1 (any cycle, tick or not):
    - score+1 (saturating).
    - Park hidden and active=0 on the same edge; wait counter=0 -> WAIT.
  - Else if fall_y >= FLOOR_Y (evaluated every cycle on the registered value):
    - miss=1 for one cycle, lives-1, park hidden.
    - If lives was 1 -> OVER, else -> WAIT.
  - Collision and floor in the same cycle: collision wins; no miss, no life lost.
  - fall_y arithmetic is 10-bit. FLOOR_Y <= 1000 guarantees no wrap before the floor check.
  - fall_x is constant during FALL.
  - start is ignored.
- State WAIT:
  - Outputs hidden.
  - Counts ticks; after RESPAWN_TICKS ticks -> SPAWN.
  - collision is ignored.
- State OVER:
  - game_over=1, outputs hidden, lives=0.
  - start -> reload lives/score -> SPAWN.
- collision is ignored in every state except FALL, so a stale flag arriving after parking does not double-count.
- rst mid-FALL: the block vanishes immediately (async), score and lives return to their reset values, state IDLE.
- miss is only ever asserted on the FALL -> WAIT/OVER edge, never in any other state.

Test Plan:
- Bench configuration: TICK_DIV=4, RESPAWN_TICKS=2, SPAWN_Y=0, FLOOR_Y=20, LIVES=2.
- Reset then idle 50 cycles -> active=0, fall_y=3FF, fall_x=0, lives=2, score=0, game_over=0.
- Pulse start; let the block fall with no collision:
  - fall_y steps 0,1,2,... once per 4 cycles.
  - At fall_y=20: miss pulses exactly 1 cycle, lives=1.
  - Hidden for 2 ticks, then re-spawns with fall_y=0 and fall_color != 0.
- Assert collision for 1 cycle while fall_y=7 -> next edge: score=1, active=0, fall_y=3FF, no miss.
  - Re-assert collision during WAIT -> score stays 1.
- Catch 4 blocks -> fifth block's fall_y advances by 2 per tick. Catch 12 -> step 4. Catch 16 -> step remains 4.
- Second miss with lives=1 -> lives=0, game_over=1, outputs hidden.
  - start -> lives=2, score=0, game_over=0, new spawn within 2 cycles.
- Drive collision=1 on the same cycle fall_y reaches 20 -> score increments, miss stays 0, lives unchanged.
  - Then assert rst mid-FALL -> all outputs at reset values asynchronously.
  - Over 1000 spawns: fall_x within 40..551, fall_color never 00.

Source files
------------

// File: rtl/faller.sv
// faller: falling-block producer for the stack collision stage.
//   Spawns one block at a pseudo-random x with a pseudo-random non-zero
//   colour, moves it down once per motion tick, retires it on a catch
//   (collision) or at the floor (miss), and sequences lives/score/game over.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   start      in   start/restart pulse (honoured in IDLE and OVER only)
//   collision  in   registered catch flag from the stack stage
//   fall_x     out  block x (top-left), 0 when hidden
//   fall_y     out  block y (top-left), 10'h3FF when hidden
//   fall_color out  block colour, never 2'b00 while active
//   active     out  block visible and falling
//   miss       out  one-cycle pulse when the block reaches the floor
//   lives      out  remaining lives
//   score      out  blocks caught, saturating at 255
//   game_over  out  high while in OVER
module faller #(
    parameter int TICK_DIV      = 250000,
    parameter int SPAWN_Y       = 0,
    parameter int FLOOR_Y       = 470,
    parameter int X_MIN         = 40,
    parameter int RESPAWN_TICKS = 30,
    parameter int LIVES         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       collision,
    output logic [9:0] fall_x,
    output logic [9:0] fall_y,
    output logic [1:0] fall_color,
    output logic       active,
    output logic       miss,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over
);

    localparam int         DIV_W  = $clog2(TICK_DIV);
    localparam int         WAIT_W = $clog2(RESPAWN_TICKS + 1);
    localparam logic [9:0] HIDE_Y = 10'h3FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FALL,
        S_WAIT,
        S_OVER
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [15:0]       lfsr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        step;
    logic [1:0]        spawn_color;

    // Free-running motion tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

    // Fibonacci LFSR, taps 16,14,13,11; runs in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Speed grows every 4 catches: 1 + min(score>>2, 3).
    always_comb begin
        step = (|score[7:4]) ? 3'd4 : ({1'b0, score[3:2]} + 3'd1);
    end

    always_comb begin
        spawn_color = (lfsr[11:10] == 2'b00) ? 2'b01 : lfsr[11:10];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            fall_x     <= '0;
            fall_y     <= HIDE_Y;
            fall_color <= '0;
            active     <= 1'b0;
            miss       <= 1'b0;
            lives      <= 2'(LIVES);
            score      <= '0;
            game_over  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            miss <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lives <= 2'(LIVES);
                        score <= '0;
                        state <= S_SPAWN;
                    end
                end

                S_SPAWN: begin
                    fall_x     <= 10'(X_MIN) + {1'b0, lfsr[8:0]};
                    fall_color <= spawn_color;
                    fall_y     <= 10'(SPAWN_Y);
                    active     <= 1'b1;
                    state      <= S_FALL;
                end

                S_FALL: begin
                    // A catch outranks a simultaneous floor hit.
                    if (collision) begin
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                        fall_x     <= '0;
                        fall_y     <= HIDE_Y;
                        fall_color <= '0;
                        active     <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= S_WAIT;
                    end else if (fall_y >= 10'(FLOOR_Y)) begin
                        miss       <= 1'b1;
                        lives      <= lives - 2'd1;
                        fall_x     <= '0;
                        fall_y     <= HIDE_Y;
                        fall_color <= '0;
                        active     <= 1'b0;
                        wait_cnt   <= '0;
                        if (lives == 2'd1) begin
                            game_over <= 1'b1;
                            state     <= S_OVER;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (tick) begin
                        fall_y <= fall_y + 10'(step);
                    end
                end

                S_WAIT: begin
                    if (tick) begin
                        if (wait_cnt == WAIT_W'(RESPAWN_TICKS - 1)) begin
                            state <= S_SPAWN;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end

                S_OVER: begin
                    lives <= '0;
                    if (start) begin
                        lives     <= 2'(LIVES);
                        score     <= '0;
                        game_over <= 1'b0;
                        state     <= S_SPAWN;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
